id_ex_pipe_reg: RTL

//  ID/EX pipeline register directly downstream of the decode controller. Latches controller

---
 rtl/id_ex_pipe_reg_if.sv | 47 ++++
 rtl/id_ex_pipe_reg.sv | 133 +++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage bundle: decoded ID fields in, registered EX fields out, plus the stall/flush
// controls and hazard statistics.
interface id_ex_pipe_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rdata1, id_rdata2, id_imm;
  logic [3:0]      id_aluop;
  logic            id_rf_en, id_sel_a, id_sel_b, id_rd_en, id_wr_en, id_jump;
  logic [1:0]      id_wb_sel;
  logic [2:0]      id_mem_mode, id_br_type;
  logic            ext_stall, ex_flush;

  logic            ex_valid;
  logic [6:0]      ex_opcode;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [3:0]      ex_aluop;
  logic            ex_rf_en, ex_sel_a, ex_sel_b, ex_rd_en, ex_wr_en, ex_jump;
  logic [1:0]      ex_wb_sel;
  logic [2:0]      ex_mem_mode, ex_br_type;
  logic            stall_id;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output id_valid, id_opcode, id_pc, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2, id_imm,
           id_aluop, id_rf_en, id_sel_a, id_sel_b, id_rd_en, id_wr_en, id_jump, id_wb_sel,
           id_mem_mode, id_br_type, ext_stall, ex_flush,
    input  ex_valid, ex_opcode, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2, ex_imm,
           ex_aluop, ex_rf_en, ex_sel_a, ex_sel_b, ex_rd_en, ex_wr_en, ex_jump, ex_wb_sel,
           ex_mem_mode, ex_br_type, stall_id, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_pc, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2, id_imm,
           id_aluop, id_rf_en, id_sel_a, id_sel_b, id_rd_en, id_wr_en, id_jump, id_wb_sel,
           id_mem_mode, id_br_type, ext_stall, ex_flush,
    output ex_valid, ex_opcode, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2, ex_imm,
           ex_aluop, ex_rf_en, ex_sel_a, ex_sel_b, ex_rd_en, ex_wr_en, ex_jump, ex_wb_sel,
           ex_mem_mode, ex_br_type, stall_id, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and EX flush.
// Define HAZARD_STATS_EN to build the stall/flush statistic counters (otherwise they read 0).
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic            clk,
  input logic            rst,
  id_ex_pipe_reg_if.slave bus
);
  typedef struct packed {
    logic            valid;
    logic [6:0]      opcode;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic [3:0]      aluop;
    logic            rf_en;
    logic            sel_a;
    logic            sel_b;
    logic            rd_en;
    logic            wr_en;
    logic            jump;
    logic [1:0]      wb_sel;
    logic [2:0]      mem_mode;
    logic [2:0]      br_type;
  } stage_t;

  stage_t id_s, ex_q, bubble;
  logic   use_rs1, use_rs2, load_use;

  // A bubble is the reset image: no writes, and br_type parked on "no branch".
  always_comb begin
    bubble         = '0;
    bubble.br_type = 3'b010;
  end

  always_comb begin
    id_s          = '0;
    id_s.valid    = bus.id_valid;
    id_s.opcode   = bus.id_opcode;
    id_s.pc       = bus.id_pc;
    id_s.rs1      = bus.id_rs1;
    id_s.rs2      = bus.id_rs2;
    id_s.rd       = bus.id_rd;
    id_s.rdata1   = bus.id_rdata1;
    id_s.rdata2   = bus.id_rdata2;
    id_s.imm      = bus.id_imm;
    id_s.aluop    = bus.id_aluop;
    id_s.rf_en    = bus.id_rf_en;
    id_s.sel_a    = bus.id_sel_a;
    id_s.sel_b    = bus.id_sel_b;
    id_s.rd_en    = bus.id_rd_en;
    id_s.wr_en    = bus.id_wr_en;
    id_s.jump     = bus.id_jump;
    id_s.wb_sel   = bus.id_wb_sel;
    id_s.mem_mode = bus.id_mem_mode;
    id_s.br_type  = bus.id_br_type;
  end

  // Which source operands the ID instruction actually reads (LUI/AUIPC/JAL read none).
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (bus.id_opcode)
      7'h37, 7'h17, 7'h6F: use_rs1 = 1'b0;
      default:             use_rs1 = 1'b1;
    endcase
    case (bus.id_opcode)
      7'h33, 7'h23, 7'h63: use_rs2 = 1'b1;
      default:             use_rs2 = 1'b0;
    endcase
  end

  assign load_use = ex_q.valid && ex_q.rd_en && (ex_q.rd != 5'd0) && bus.id_valid &&
                    ((use_rs1 && (bus.id_rs1 == ex_q.rd)) ||
                     (use_rs2 && (bus.id_rs2 == ex_q.rd)));

  assign bus.stall_id = load_use && !bus.ex_flush && !bus.ext_stall;

  always_ff @(posedge clk) begin
    if (rst)                                ex_q <= bubble;
    else if (!bus.ext_stall) begin
      if (bus.ex_flush || load_use)         ex_q <= bubble;
      else                                  ex_q <= id_s;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // A flush swallows a coincident load-use, so only one of the two counts per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!bus.ext_stall) begin
      if (bus.ex_flush)   flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      else if (load_use)  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_opcode   = ex_q.opcode;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_rdata1   = ex_q.rdata1;
  assign bus.ex_rdata2   = ex_q.rdata2;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_aluop    = ex_q.aluop;
  assign bus.ex_rf_en    = ex_q.rf_en;
  assign bus.ex_sel_a    = ex_q.sel_a;
  assign bus.ex_sel_b    = ex_q.sel_b;
  assign bus.ex_rd_en    = ex_q.rd_en;
  assign bus.ex_wr_en    = ex_q.wr_en;
  assign bus.ex_jump     = ex_q.jump;
  assign bus.ex_wb_sel   = ex_q.wb_sel;
  assign bus.ex_mem_mode = ex_q.mem_mode;
  assign bus.ex_br_type  = ex_q.br_type;
endmodule
